// File: rtl/alt_vipvfr_prc_queue_core.sv
// Packet reader core: descriptor queue, header beat, burst-split payload fetch, Avalon-ST output.
// Optional frame repeat of the last popped descriptor: define PRC_REPEAT_LAST_EN.
module alt_vipvfr_prc_queue_core #(
   parameter int BITS_PER_SYMBOL  = 8,
   parameter int SYMBOLS_PER_BEAT = 3,
   parameter int BYTES_PER_BEAT   = 4,
   parameter int MAX_BURST        = 64,
   parameter int BURST_WIDTH      = 7,
   parameter int SAMPLES_WIDTH    = 32,
   parameter int DESC_DEPTH       = 4,
   localparam int DW              = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
   localparam int AW              = $clog2(DESC_DEPTH)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   input  logic [31:0]              desc_addr,
   input  logic [3:0]               desc_type,
   input  logic [SAMPLES_WIDTH-1:0] desc_samples,
   output logic [AW:0]              queue_level,
   output logic                     busy,
   output logic                     complete,
   output logic                     cmd,
   input  logic                     cmd_ready,
   output logic [31:0]              cmd_addr,
   output logic [BURST_WIDTH-1:0]   cmd_length_of_burst,
   input  logic                     rd_valid,
   output logic                     rd_ready,
   input  logic [DW-1:0]            rd_data,
   input  logic                     ready_out,
   output logic                     valid_out,
   output logic [DW-1:0]            data_out,
   output logic                     sop_out,
   output logic                     eop_out
);

   localparam int LW = AW + 1;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HEADER = 3'd1;
   localparam logic [2:0] ST_CMD    = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   localparam logic [AW-1:0]            PTR_ONE  = AW'(1);
   localparam logic [LW-1:0]            LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]            LVL_FULL = LW'(DESC_DEPTH);
   localparam logic [SAMPLES_WIDTH-1:0] SMP_ONE  = SAMPLES_WIDTH'(1);
   localparam logic [SAMPLES_WIDTH-1:0] SMP_MAXB = SAMPLES_WIDTH'(MAX_BURST);
   localparam logic [BURST_WIDTH-1:0]   BST_ONE  = BURST_WIDTH'(1);
   localparam logic [BURST_WIDTH-1:0]   BST_MAX  = BURST_WIDTH'(MAX_BURST);
   localparam logic [31:0]              BYTE_STEP = 32'(BYTES_PER_BEAT);

   // Descriptor storage
   logic [31:0]              q_addr_q    [DESC_DEPTH];
   logic [3:0]               q_type_q    [DESC_DEPTH];
   logic [SAMPLES_WIDTH-1:0] q_samples_q [DESC_DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]            level_q, level_d;
   logic                     push_s;
   logic                     pop_s;

   // Working registers of the packet in flight
   logic [2:0]               state_q, state_d;
   logic [31:0]              addr_q, addr_d;
   logic [3:0]               type_q, type_d;
   logic [SAMPLES_WIDTH-1:0] samples_q, samples_d;
   logic [SAMPLES_WIDTH-1:0] remaining_q, remaining_d;
   logic [SAMPLES_WIDTH-1:0] sent_q, sent_d;
   logic [BURST_WIDTH-1:0]   burst_left_q, burst_left_d;
   logic [BURST_WIDTH-1:0]   len_s;
   logic [DW-1:0]            last_data_q;

`ifdef PRC_REPEAT_LAST_EN
   logic                     have_last_q;
   logic [31:0]              rep_addr_q;
   logic [3:0]               rep_type_q;
   logic [SAMPLES_WIDTH-1:0] rep_samples_q;
`endif

   // Burst length: whatever is left, clipped to the largest legal burst
   always_comb begin
      if (remaining_q > SMP_MAXB) begin
         len_s = BST_MAX;
      end else begin
         len_s = remaining_q[BURST_WIDTH-1:0];
      end
   end

   // Packet sequencing and working-register next state
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      type_d       = type_q;
      samples_d    = samples_q;
      remaining_d  = remaining_q;
      sent_d       = sent_q;
      burst_left_d = burst_left_q;
      pop_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && (level_q != '0)) begin
               pop_s        = 1'b1;
               addr_d       = q_addr_q[rd_ptr_q];
               type_d       = q_type_q[rd_ptr_q];
               samples_d    = q_samples_q[rd_ptr_q];
               remaining_d  = q_samples_q[rd_ptr_q];
               sent_d       = '0;
               burst_left_d = '0;
               state_d      = ST_HEADER;
            end
`ifdef PRC_REPEAT_LAST_EN
            else if (enable && have_last_q) begin
               addr_d       = rep_addr_q;
               type_d       = rep_type_q;
               samples_d    = rep_samples_q;
               remaining_d  = rep_samples_q;
               sent_d       = '0;
               burst_left_d = '0;
               state_d      = ST_HEADER;
            end
`endif
            else begin
               state_d = ST_IDLE;
            end
         end
         ST_HEADER: begin
            if (ready_out) begin
               if (samples_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CMD;
               end
            end else begin
               state_d = ST_HEADER;
            end
         end
         ST_CMD: begin
            if (cmd_ready) begin
               addr_d       = addr_q + (32'(len_s) * BYTE_STEP);
               remaining_d  = remaining_q - SAMPLES_WIDTH'(len_s);
               burst_left_d = len_s;
               state_d      = ST_STREAM;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_STREAM: begin
            if (rd_valid && ready_out) begin
               sent_d       = sent_q + SMP_ONE;
               burst_left_d = burst_left_q - BST_ONE;
               if (burst_left_q == BST_ONE) begin
                  if (remaining_q != '0) begin
                     state_d = ST_CMD;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Queue pointers and occupancy; a full queue refuses pushes, so push+pop never meets full
   always_comb begin
      push_s   = desc_valid & desc_ready;
      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   // Output decode; STREAM is a straight pass-through between read master and sink
   always_comb begin
      valid_out           = 1'b0;
      sop_out             = 1'b0;
      eop_out             = 1'b0;
      data_out            = last_data_q;
      cmd                 = 1'b0;
      cmd_addr            = '0;
      cmd_length_of_burst = '0;
      rd_ready            = 1'b0;
      case (state_q)
         ST_HEADER: begin
            valid_out = 1'b1;
            sop_out   = 1'b1;
            eop_out   = (samples_q == '0);
            data_out  = DW'(type_q);
         end
         ST_CMD: begin
            cmd                 = 1'b1;
            cmd_addr            = addr_q;
            cmd_length_of_burst = len_s;
         end
         ST_STREAM: begin
            valid_out = rd_valid;
            rd_ready  = ready_out;
            data_out  = rd_data;
            eop_out   = (sent_q == (samples_q - SMP_ONE));
         end
         default: begin
            valid_out = 1'b0;
         end
      endcase
      busy        = (state_q != ST_IDLE);
      complete    = (state_q == ST_DONE);
      desc_ready  = (level_q != LVL_FULL);
      queue_level = level_q;
   end

   // Descriptor payload storage; contents are only meaningful between push and pop
   always_ff @(posedge clock) begin
      if (push_s) begin
         q_addr_q[wr_ptr_q]    <= desc_addr;
         q_type_q[wr_ptr_q]    <= desc_type;
         q_samples_q[wr_ptr_q] <= desc_samples;
      end
   end

   // Control and working state
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         addr_q       <= '0;
         type_q       <= '0;
         samples_q    <= '0;
         remaining_q  <= '0;
         sent_q       <= '0;
         burst_left_q <= '0;
         last_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         addr_q       <= addr_d;
         type_q       <= type_d;
         samples_q    <= samples_d;
         remaining_q  <= remaining_d;
         sent_q       <= sent_d;
         burst_left_q <= burst_left_d;
         last_data_q  <= data_out;
      end
   end

`ifdef PRC_REPEAT_LAST_EN
   // Copy of the most recently popped descriptor, replayed while the queue is empty
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         have_last_q   <= 1'b0;
         rep_addr_q    <= '0;
         rep_type_q    <= '0;
         rep_samples_q <= '0;
      end else if (pop_s) begin
         have_last_q   <= 1'b1;
         rep_addr_q    <= q_addr_q[rd_ptr_q];
         rep_type_q    <= q_type_q[rd_ptr_q];
         rep_samples_q <= q_samples_q[rd_ptr_q];
      end else begin
         have_last_q   <= have_last_q;
         rep_addr_q    <= rep_addr_q;
         rep_type_q    <= rep_type_q;
         rep_samples_q <= rep_samples_q;
      end
   end
`endif

endmodule

// File: tb/tb_alt_vipvfr_prc_queue_core.sv
// Directed self-checking bench for alt_vipvfr_prc_queue_core with a burst-serving memory responder.
module tb_alt_vipvfr_prc_queue_core;

   localparam int DW = 24;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          desc_valid = 1'b0;
   logic          desc_ready;
   logic [31:0]   desc_addr = 32'h0;
   logic [3:0]    desc_type = 4'h0;
   logic [31:0]   desc_samples = 32'h0;
   logic [2:0]    queue_level;
   logic          busy;
   logic          complete;
   logic          cmd;
   logic          cmd_ready = 1'b1;
   logic [31:0]   cmd_addr;
   logic [6:0]    cmd_length_of_burst;
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          ready_out = 1'b0;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          sop_out;
   logic          eop_out;

   int vectors = 0;
   int miscompares = 0;
   int complete_cnt = 0;
   int flush_req = 0;
   int flush_ack = 0;
   logic [DW+1:0] beat_log[$];
   logic [31:0]   cmd_addr_log[$];
   int            cmd_len_log[$];

   alt_vipvfr_prc_queue_core #(
      .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .BYTES_PER_BEAT(4), .MAX_BURST(64),
      .BURST_WIDTH(7), .SAMPLES_WIDTH(32), .DESC_DEPTH(4)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_addr(desc_addr),
      .desc_type(desc_type), .desc_samples(desc_samples), .queue_level(queue_level),
      .busy(busy), .complete(complete), .cmd(cmd), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_length_of_burst(cmd_length_of_burst),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
      .sop_out(sop_out), .eop_out(eop_out)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
      return {8'hC3, a[15:0]};
   endfunction

   function automatic logic [DW+1:0] get_beat(input int idx);
      if (idx < beat_log.size()) return beat_log[idx];
      else return 'x;
   endfunction

   function automatic logic [31:0] get_cmd_addr(input int idx);
      if (idx < cmd_addr_log.size()) return cmd_addr_log[idx];
      else return 'x;
   endfunction

   function automatic int get_cmd_len(input int idx);
      if (idx < cmd_len_log.size()) return cmd_len_log[idx];
      else return -1;
   endfunction

   // Memory responder: serves accepted bursts in order, one beat per accepted transfer
   initial begin
      logic [31:0] pend_addr[$];
      int          pend_len[$];
      int          beat_idx;
      bit          c_fire, r_fire;
      logic [31:0] c_addr;
      int          c_len;
      beat_idx = 0;
      rd_valid = 1'b0;
      rd_data  = '0;
      forever begin
         @(negedge clock);
         c_fire = cmd && cmd_ready;
         c_addr = cmd_addr;
         c_len  = int'(cmd_length_of_burst);
         r_fire = rd_valid && rd_ready;
         @(posedge clock);
         #1;
         if (flush_req != flush_ack) begin
            pend_addr.delete();
            pend_len.delete();
            beat_idx  = 0;
            flush_ack = flush_req;
         end else begin
            if (r_fire && pend_len.size() > 0) begin
               beat_idx++;
               if (beat_idx == pend_len[0]) begin
                  void'(pend_addr.pop_front());
                  void'(pend_len.pop_front());
                  beat_idx = 0;
               end
            end
            if (c_fire) begin
               pend_addr.push_back(c_addr);
               pend_len.push_back(c_len);
            end
         end
         if (pend_addr.size() > 0) begin
            rd_valid = 1'b1;
            rd_data  = mem_word(pend_addr[0] + 32'(beat_idx * 4));
         end else begin
            rd_valid = 1'b0;
         end
      end
   end

   // Output monitor: logs accepted beats, accepted commands and completion pulses
   initial begin
      forever begin
         @(negedge clock);
         if (valid_out && ready_out) beat_log.push_back({sop_out, eop_out, data_out});
         if (cmd && cmd_ready) begin
            cmd_addr_log.push_back(cmd_addr);
            cmd_len_log.push_back(int'(cmd_length_of_burst));
         end
         if (complete) complete_cnt++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic push_desc(input logic [31:0] a, input logic [3:0] t, input logic [31:0] s);
      desc_addr    = a;
      desc_type    = t;
      desc_samples = s;
      desc_valid   = 1'b1;
      tick();
      desc_valid   = 1'b0;
   endtask

   task automatic wait_complete(input int target, input int budget, output bit ok);
      int n = 0;
      while (complete_cnt < target && n < budget) begin
         tick();
         n++;
      end
      ok = (complete_cnt >= target);
   endtask

   task automatic test_reset();
      logic [7:0] obs;
      reset_n = 1'b0;
      repeat (3) tick();
      @(negedge clock);
      obs = {valid_out, sop_out, eop_out, cmd, rd_ready, busy, complete, desc_ready};
      vectors++; if (obs !== 8'b0000_0001) begin $display("FAIL reset_flags: got %b want %b", obs, 8'b0000_0001); miscompares++; end
      vectors++; if (queue_level !== 3'd0) begin $display("FAIL reset_level: got %0d want 0", queue_level); miscompares++; end
      vectors++; if (data_out !== 24'h0) begin $display("FAIL reset_data: got %h want 000000", data_out); miscompares++; end
      vectors++; if (cmd_addr !== 32'h0 || cmd_length_of_burst !== 7'd0) begin $display("FAIL reset_cmd: got %h/%0d want 0/0", cmd_addr, cmd_length_of_burst); miscompares++; end
      @(posedge clock);
      #2;
      reset_n   = 1'b1;
      ready_out = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int b0 = beat_log.size();
      int c0 = cmd_addr_log.size();
      int p0 = complete_cnt;
      bit ok;
      logic [DW+1:0] exp_b[4];
      exp_b[0] = {2'b10, 24'h000000};
      exp_b[1] = {2'b00, 24'hC31000};
      exp_b[2] = {2'b00, 24'hC31004};
      exp_b[3] = {2'b01, 24'hC31008};
      push_desc(32'h1000, 4'h0, 32'd3);
      vectors++; if (queue_level !== 3'd1) begin $display("FAIL basic_level: got %0d want 1", queue_level); miscompares++; end
      vectors++; if (busy !== 1'b0) begin $display("FAIL basic_idle_busy: got %b want 0", busy); miscompares++; end
      enable = 1'b1;
      wait_complete(p0 + 1, 200, ok);
      enable = 1'b0;
      vectors++; if (!ok) begin $display("FAIL basic_timeout: got %0d completes want %0d", complete_cnt - p0, 1); miscompares++; end
      repeat (4) tick();
      vectors++; if (beat_log.size() - b0 != 4) begin $display("FAIL basic_beat_count: got %0d want 4", beat_log.size() - b0); miscompares++; end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (get_beat(b0 + i) !== exp_b[i]) begin $display("FAIL basic_beat%0d: got %h want %h", i, get_beat(b0 + i), exp_b[i]); miscompares++; end
      end
      vectors++; if (cmd_addr_log.size() - c0 != 1) begin $display("FAIL basic_cmd_count: got %0d want 1", cmd_addr_log.size() - c0); miscompares++; end
      vectors++; if (get_cmd_addr(c0) !== 32'h1000 || get_cmd_len(c0) != 3) begin $display("FAIL basic_cmd: got %h/%0d want 00001000/3", get_cmd_addr(c0), get_cmd_len(c0)); miscompares++; end
      vectors++; if (complete_cnt - p0 != 1) begin $display("FAIL basic_complete: got %0d want 1", complete_cnt - p0); miscompares++; end
   endtask

   task automatic test_multi_burst();
      int b0 = beat_log.size();
      int c0 = cmd_addr_log.size();
      int p0 = complete_cnt;
      int bad = 0;
      bit ok;
      logic [31:0]   exp_ca[3];
      int            exp_cl[3];
      logic [31:0]   a;
      logic [DW+1:0] e;
      exp_ca[0] = 32'h2000; exp_cl[0] = 64;
      exp_ca[1] = 32'h2100; exp_cl[1] = 64;
      exp_ca[2] = 32'h2200; exp_cl[2] = 22;
      push_desc(32'h2000, 4'h5, 32'd150);
      enable = 1'b1;
      wait_complete(p0 + 1, 1000, ok);
      enable = 1'b0;
      vectors++; if (!ok) begin $display("FAIL multi_timeout: got %0d completes want 1", complete_cnt - p0); miscompares++; end
      repeat (4) tick();
      vectors++; if (beat_log.size() - b0 != 151) begin $display("FAIL multi_beat_count: got %0d want 151", beat_log.size() - b0); miscompares++; end
      vectors++; if (get_beat(b0) !== {2'b10, 24'h000005}) begin $display("FAIL multi_header: got %h want %h", get_beat(b0), {2'b10, 24'h000005}); miscompares++; end
      for (int i = 0; i < 150; i++) begin
         a = 32'h2000 + 32'(4 * i);
         e = {1'b0, (i == 149), mem_word(a)};
         vectors++;
         if (get_beat(b0 + 1 + i) !== e) begin
            miscompares++;
            if (bad < 5) $display("FAIL multi_beat%0d: got %h want %h", i, get_beat(b0 + 1 + i), e);
            bad++;
         end
      end
      vectors++; if (cmd_addr_log.size() - c0 != 3) begin $display("FAIL multi_cmd_count: got %0d want 3", cmd_addr_log.size() - c0); miscompares++; end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (get_cmd_addr(c0 + i) !== exp_ca[i] || get_cmd_len(c0 + i) != exp_cl[i]) begin
            $display("FAIL multi_cmd%0d: got %h/%0d want %h/%0d", i, get_cmd_addr(c0 + i), get_cmd_len(c0 + i), exp_ca[i], exp_cl[i]);
            miscompares++;
         end
      end
   endtask

   task automatic test_zero_samples();
      int b0 = beat_log.size();
      int c0 = cmd_addr_log.size();
      int p0 = complete_cnt;
      bit ok;
      push_desc(32'h3000, 4'hF, 32'd0);
      enable = 1'b1;
      wait_complete(p0 + 1, 50, ok);
      enable = 1'b0;
      vectors++; if (!ok) begin $display("FAIL zero_timeout: got %0d completes want 1", complete_cnt - p0); miscompares++; end
      repeat (4) tick();
      vectors++; if (beat_log.size() - b0 != 1) begin $display("FAIL zero_beat_count: got %0d want 1", beat_log.size() - b0); miscompares++; end
      vectors++; if (get_beat(b0) !== {2'b11, 24'h00000F}) begin $display("FAIL zero_beat: got %h want %h", get_beat(b0), {2'b11, 24'h00000F}); miscompares++; end
      vectors++; if (cmd_addr_log.size() != c0) begin $display("FAIL zero_no_cmd: got %0d cmds want 0", cmd_addr_log.size() - c0); miscompares++; end
      vectors++; if (complete_cnt - p0 != 1) begin $display("FAIL zero_complete: got %0d want 1", complete_cnt - p0); miscompares++; end
   endtask

   task automatic test_queue_full();
      int b0 = beat_log.size();
      int c0 = cmd_addr_log.size();
      int p0 = complete_cnt;
      int nsop = 0;
      int neop = 0;
      bit ok;
      logic [DW+1:0] bt;
      for (int k = 0; k < 4; k++) push_desc(32'h4000 + 32'(k * 256), 4'(k + 1), 32'(k + 1));
      vectors++; if (desc_ready !== 1'b0) begin $display("FAIL full_ready: got %b want 0", desc_ready); miscompares++; end
      vectors++; if (queue_level !== 3'd4) begin $display("FAIL full_level: got %0d want 4", queue_level); miscompares++; end
      push_desc(32'h4400, 4'h5, 32'd5);
      vectors++; if (queue_level !== 3'd4) begin $display("FAIL full_fifth_ignored: got %0d want 4", queue_level); miscompares++; end
      enable = 1'b1;
      wait_complete(p0 + 4, 300, ok);
      enable = 1'b0;
      vectors++; if (!ok) begin $display("FAIL full_timeout: got %0d completes want 4", complete_cnt - p0); miscompares++; end
      repeat (20) tick();
      vectors++; if (complete_cnt - p0 != 4 || queue_level !== 3'd0) begin $display("FAIL full_drain: got %0d completes level %0d want 4/0", complete_cnt - p0, queue_level); miscompares++; end
      vectors++; if (beat_log.size() - b0 != 14) begin $display("FAIL full_beat_count: got %0d want 14", beat_log.size() - b0); miscompares++; end
      for (int i = b0; i < beat_log.size(); i++) begin
         bt = beat_log[i];
         if (bt[DW]) neop++;
         if (bt[DW+1]) begin
            nsop++;
            vectors++;
            if (bt[DW-1:0] !== 24'(nsop)) begin $display("FAIL full_order%0d: got %h want %h", nsop, bt[DW-1:0], 24'(nsop)); miscompares++; end
         end
      end
      vectors++; if (nsop != 4 || neop != 4) begin $display("FAIL full_sop_eop: got %0d/%0d want 4/4", nsop, neop); miscompares++; end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (get_cmd_addr(c0 + k) !== 32'h4000 + 32'(k * 256) || get_cmd_len(c0 + k) != k + 1) begin
            $display("FAIL full_cmd%0d: got %h/%0d want %h/%0d", k, get_cmd_addr(c0 + k), get_cmd_len(c0 + k), 32'h4000 + 32'(k * 256), k + 1);
            miscompares++;
         end
      end
   endtask

   task automatic test_backpressure();
      int b0 = beat_log.size();
      int p0 = complete_cnt;
      int n = 0;
      logic [DW+1:0] e;
      push_desc(32'h5000, 4'h2, 32'd10);
      enable = 1'b1;
      while (complete_cnt < p0 + 1 && n < 500) begin
         @(posedge clock);
         #2;
         ready_out = 1'($urandom_range(0, 1));
         n++;
         @(negedge clock);
         vectors++;
         if (!ready_out && rd_ready !== 1'b0) begin $display("FAIL bp_rd_ready: got %b want 0", rd_ready); miscompares++; end
      end
      enable    = 1'b0;
      ready_out = 1'b1;
      vectors++; if (complete_cnt < p0 + 1) begin $display("FAIL bp_timeout: got %0d completes want 1", complete_cnt - p0); miscompares++; end
      repeat (4) tick();
      vectors++; if (beat_log.size() - b0 != 11) begin $display("FAIL bp_beat_count: got %0d want 11", beat_log.size() - b0); miscompares++; end
      vectors++; if (get_beat(b0) !== {2'b10, 24'h000002}) begin $display("FAIL bp_header: got %h want %h", get_beat(b0), {2'b10, 24'h000002}); miscompares++; end
      for (int i = 0; i < 10; i++) begin
         e = {1'b0, (i == 9), mem_word(32'h5000 + 32'(4 * i))};
         vectors++;
         if (get_beat(b0 + 1 + i) !== e) begin $display("FAIL bp_beat%0d: got %h want %h", i, get_beat(b0 + 1 + i), e); miscompares++; end
      end
   endtask

   task automatic test_reset_mid();
      int b0 = beat_log.size();
      int c0;
      int p0 = complete_cnt;
      int n = 0;
      bit ok;
      bit any_busy = 1'b0;
      logic [7:0] obs;
      push_desc(32'h6000, 4'h6, 32'd40);
      push_desc(32'h6400, 4'h7, 32'd4);
      push_desc(32'h6800, 4'h8, 32'd4);
      enable = 1'b1;
      while (beat_log.size() - b0 < 6 && n < 100) begin
         tick();
         n++;
      end
      vectors++; if (beat_log.size() - b0 < 6 || queue_level !== 3'd2) begin $display("FAIL rstmid_setup: got %0d beats level %0d want >=6/2", beat_log.size() - b0, queue_level); miscompares++; end
      reset_n = 1'b0;
      flush_req++;
      @(posedge clock);
      @(negedge clock);
      obs = {valid_out, sop_out, eop_out, cmd, rd_ready, busy, complete, desc_ready};
      vectors++; if (obs !== 8'b0000_0001) begin $display("FAIL rstmid_flags: got %b want %b", obs, 8'b0000_0001); miscompares++; end
      vectors++; if (queue_level !== 3'd0) begin $display("FAIL rstmid_level: got %0d want 0", queue_level); miscompares++; end
      vectors++; if (data_out !== 24'h0) begin $display("FAIL rstmid_data: got %h want 000000", data_out); miscompares++; end
      vectors++; if (cmd_addr !== 32'h0 || cmd_length_of_burst !== 7'd0) begin $display("FAIL rstmid_cmd: got %h/%0d want 0/0", cmd_addr, cmd_length_of_burst); miscompares++; end
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy !== 1'b0) any_busy = 1'b1;
      end
      vectors++; if (any_busy || complete_cnt != p0) begin $display("FAIL rstmid_stay_idle: got busy %b completes %0d want 0/0", any_busy, complete_cnt - p0); miscompares++; end
      b0 = beat_log.size();
      c0 = cmd_addr_log.size();
      push_desc(32'h7000, 4'h3, 32'd2);
`ifdef PRC_REPEAT_LAST_EN
      wait_complete(p0 + 3, 200, ok);
      enable = 1'b0;
      vectors++; if (!ok) begin $display("FAIL repeat_timeout: got %0d completes want 3", complete_cnt - p0); miscompares++; end
      repeat (10) tick();
      vectors++; if (beat_log.size() - b0 < 9) begin $display("FAIL repeat_beats: got %0d want >=9", beat_log.size() - b0); miscompares++; end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (get_beat(b0 + 3 * i) !== {2'b10, 24'h000003} || get_cmd_addr(c0 + i) !== 32'h7000) begin
            $display("FAIL repeat_pkt%0d: got %h/%h want %h/00007000", i, get_beat(b0 + 3 * i), get_cmd_addr(c0 + i), {2'b10, 24'h000003});
            miscompares++;
         end
      end
`else
      wait_complete(p0 + 1, 50, ok);
      vectors++; if (!ok) begin $display("FAIL post_rst_timeout: got %0d completes want 1", complete_cnt - p0); miscompares++; end
      repeat (30) tick();
      vectors++; if (complete_cnt - p0 != 1 || busy !== 1'b0) begin $display("FAIL post_rst_no_repeat: got %0d completes busy %b want 1/0", complete_cnt - p0, busy); miscompares++; end
      vectors++; if (beat_log.size() - b0 != 3) begin $display("FAIL post_rst_beats: got %0d want 3", beat_log.size() - b0); miscompares++; end
      vectors++; if (get_beat(b0 + 2) !== {2'b01, 24'hC37004}) begin $display("FAIL post_rst_last: got %h want %h", get_beat(b0 + 2), {2'b01, 24'hC37004}); miscompares++; end
      enable = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multi_burst();
      test_zero_samples();
      test_queue_full();
      test_backpressure();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
